// File: rtl/mc_cu_pkg.sv
// ============================================================================
// Module   : mc_cu_pkg
// Brief    : State encoding, opcode constants, wb_sel codes, instruction class
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_cu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_UNKNOWN = 4'd0,
    CLS_R       = 4'd1,
    CLS_IALU    = 4'd2,
    CLS_LOAD    = 4'd3,
    CLS_STORE   = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_JAL     = 4'd6,
    CLS_JALR    = 4'd7,
    CLS_LUI     = 4'd8,
    CLS_AUIPC   = 4'd9
  } cls_t;

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_IALU   = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] c_WB_DM  = 2'b00;
  localparam logic [1:0] c_WB_ALU = 2'b01;
  localparam logic [1:0] c_WB_PC4 = 2'b10;
  localparam logic [1:0] c_WB_IMM = 2'b11;

  function automatic cls_t classify(input logic [6:0] opcode);
    case (opcode)
      c_OP_R:      classify = CLS_R;
      c_OP_IALU:   classify = CLS_IALU;
      c_OP_LOAD:   classify = CLS_LOAD;
      c_OP_STORE:  classify = CLS_STORE;
      c_OP_BRANCH: classify = CLS_BRANCH;
      c_OP_JAL:    classify = CLS_JAL;
      c_OP_JALR:   classify = CLS_JALR;
      c_OP_LUI:    classify = CLS_LUI;
      c_OP_AUIPC:  classify = CLS_AUIPC;
      default:     classify = CLS_UNKNOWN;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_cu_decoder.sv
// ============================================================================
// Module   : mc_cu_decoder
// Brief    : Combinational opcode-to-class and control-field decode of the IR
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_cu_decoder
  import mc_cu_pkg::*;
(
  input  logic [31:0] ir,
  output cls_t        cls,
  output logic [2:0]  alu_func3,
  output logic        alu_subsra,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  wb_sel,
  output logic [2:0]  br_op,
  output logic [2:0]  dm_ctrl,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  logic [2:0] w_func3;
  logic       w_unused;

  assign w_func3  = ir[14:12];
  assign w_unused = ^{ir[31], ir[29:25]};
  assign cls      = classify(ir[6:0]);
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign rd       = ir[11:7];
  assign br_op    = w_func3;
  assign dm_ctrl  = w_func3;

  always_comb begin
    alu_func3  = 3'b000;
    alu_subsra = 1'b0;
    alu_src_a  = 1'b1;
    alu_src_b  = 1'b1;
    wb_sel     = c_WB_ALU;
    case (cls)
      CLS_R: begin
        alu_func3  = w_func3;
        alu_subsra = ir[30];
        alu_src_b  = 1'b0;
      end
      CLS_IALU: begin
        alu_func3  = w_func3;
        // Only shift-right-immediate uses bit 30; elsewhere it is immediate data
        alu_subsra = (w_func3 == 3'b101) ? ir[30] : 1'b0;
      end
      CLS_LOAD:   wb_sel = c_WB_DM;
      CLS_BRANCH: begin
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
      end
      CLS_JAL: begin
        alu_src_a = 1'b0;
        wb_sel    = c_WB_PC4;
      end
      CLS_JALR:  wb_sel = c_WB_PC4;
      CLS_LUI:   wb_sel = c_WB_IMM;
      CLS_AUIPC: alu_src_a = 1'b0;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_unit.sv
// ============================================================================
// Module   : mc_control_unit
// Brief    : Multi-cycle control FSM with retired-instruction counter.
//            Optional trap on unknown opcode: define MC_CU_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_unit
  import mc_cu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 dmem_we,
  input  logic                 branch_taken,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 rf_we,
  output logic                 pc_sel,
  output logic                 alu_src_a,
  output logic                 alu_src_b,
  output logic [1:0]           wb_sel,
  output logic [2:0]           alu_func3,
  output logic                 alu_subsra,
  output logic [2:0]           br_op,
  output logic [2:0]           dm_ctrl,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret_cnt,
  output logic                 trap
);

  if (INSTRET_W > 2*XLEN) begin : g_width_check
    $error("INSTRET_W must not exceed 2*XLEN");
  end

  state_t               r_state, w_next;
  logic [31:0]          r_ir;
  logic [INSTRET_W-1:0] r_instret;
  cls_t                 w_cls;
  logic w_imem_req, w_ir_we, w_pc_we, w_pc_sel, w_rf_we, w_dmem_req, w_dmem_we;

  mc_cu_decoder u_decoder (
    .ir         (r_ir),
    .cls        (w_cls),
    .alu_func3  (alu_func3),
    .alu_subsra (alu_subsra),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .wb_sel     (wb_sel),
    .br_op      (br_op),
    .dm_ctrl    (dm_ctrl),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= FETCH;
      r_ir      <= 32'd0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_ir_we) r_ir <= instr;
      if (w_pc_we) r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_next     = r_state;
    w_imem_req = 1'b0;
    w_ir_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_sel   = 1'b0;
    w_rf_we    = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    case (r_state)
      FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ready) begin
          w_ir_we = 1'b1;
          w_next  = DECODE;
        end
      end
      DECODE: w_next = EXEC;
      EXEC: begin
        case (w_cls)
          CLS_LOAD, CLS_STORE: w_next = MEM;
          CLS_BRANCH: begin
            w_next   = FETCH;
            w_pc_we  = 1'b1;
            w_pc_sel = branch_taken;
          end
          CLS_R, CLS_IALU, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR: w_next = WB;
          default: begin
`ifdef MC_CU_TRAP_EN
            w_next  = TRAP;
`else
            w_next  = FETCH;
            w_pc_we = 1'b1;
`endif
          end
        endcase
      end
      MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (w_cls == CLS_STORE);
        if (dmem_ready) begin
          if (w_cls == CLS_STORE) begin
            w_next  = FETCH;
            w_pc_we = 1'b1;
          end else begin
            w_next = WB;
          end
        end
      end
      WB: begin
        w_rf_we  = (rd != 5'd0);
        w_pc_we  = 1'b1;
        w_pc_sel = (w_cls == CLS_JAL) || (w_cls == CLS_JALR);
        w_next   = FETCH;
      end
`ifdef MC_CU_TRAP_EN
      TRAP:    w_next = TRAP;
`endif
      default: w_next = FETCH;
    endcase
  end

  // Reset masks the enables combinationally so an in-flight access drops at once
  assign imem_req    = w_imem_req & ~reset;
  assign ir_we       = w_ir_we    & ~reset;
  assign pc_we       = w_pc_we    & ~reset;
  assign pc_sel      = w_pc_sel   & ~reset;
  assign rf_we       = w_rf_we    & ~reset;
  assign dmem_req    = w_dmem_req & ~reset;
  assign dmem_we     = w_dmem_we  & ~reset;
  assign state       = r_state;
  assign instret_cnt = r_instret;

`ifdef MC_CU_TRAP_EN
  assign trap = (r_state == TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: stimulus pushes expected retire/memory
// records, negedge monitor pops and compares when pc_we or a dmem handshake fires.
`default_nettype none

module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        reset, imem_ready, dmem_ready, branch_taken;
  logic [31:0] instr;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, pc_sel;
  logic        alu_src_a, alu_src_b, alu_subsra, trap;
  logic [1:0]  wb_sel;
  logic [2:0]  alu_func3, br_op, dm_ctrl, state;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] instret_cnt;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .instr(instr),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .dmem_we(dmem_we),
    .branch_taken(branch_taken),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .pc_sel(pc_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .wb_sel(wb_sel),
    .alu_func3(alu_func3), .alu_subsra(alu_subsra), .br_op(br_op), .dm_ctrl(dm_ctrl),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .state(state), .instret_cnt(instret_cnt), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lat;
    logic [2:0] st;
    logic       psel;
    logic       rfwe;
    logic [1:0] wb;
    logic [4:0] rd;
    logic [2:0] f3;
    logic       sub;
    int         cnt;
  } ret_t;

  typedef struct {
    logic       we;
    logic [2:0] ctrl;
    int         hold;
  } mem_t;

  ret_t ret_q[$];
  mem_t mem_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;
  int   dm_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // dmem responder: ready after dm_wait extra MEM cycles
  initial begin
    int mc;
    mc = 0;
    dmem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && state == 3'd3) begin
        dmem_ready = (mc == dm_wait);
        mc++;
      end else begin
        dmem_ready = 1'b0;
        mc = 0;
      end
    end
  end

  // Monitor
  initial begin
    int cyc, mhold;
    ret_t r;
    mem_t m;
    cyc = 0;
    mhold = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0;
        mhold = 0;
      end else begin
        cyc++;
        if (dmem_req) begin
          mhold++;
          if (dmem_ready) begin
            if (mem_q.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL mem_unexpected: got dmem handshake expected none");
            end else begin
              m = mem_q.pop_front();
              chk("dmem_we", {31'd0, dmem_we}, {31'd0, m.we});
              chk("dm_ctrl", {29'd0, dm_ctrl}, {29'd0, m.ctrl});
              chk("mem_hold", mhold, m.hold);
            end
            mhold = 0;
          end
        end
        if (pc_we) begin
          if (ret_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL ret_unexpected: got pc_we expected none");
          end else begin
            r = ret_q.pop_front();
            chk("latency",     cyc, r.lat);
            chk("ret_state",   {29'd0, state}, {29'd0, r.st});
            chk("pc_sel",      {31'd0, pc_sel}, {31'd0, r.psel});
            chk("rf_we",       {31'd0, rf_we}, {31'd0, r.rfwe});
            chk("wb_sel",      {30'd0, wb_sel}, {30'd0, r.wb});
            chk("rd",          {27'd0, rd}, {27'd0, r.rd});
            chk("alu_func3",   {29'd0, alu_func3}, {29'd0, r.f3});
            chk("alu_subsra",  {31'd0, alu_subsra}, {31'd0, r.sub});
            chk("instret_pre", instret_cnt, r.cnt);
          end
          cyc = 0;
        end
      end
    end
  end

  task automatic wait_state(input logic [2:0] s);
    int n;
    n = 0;
    while (state != s && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (state != s) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_state: got %0d expected %0d", state, s);
    end
  endtask

  task automatic fetch(input logic [31:0] ins);
    wait_state(3'd0);
    instr = ins;
    imem_ready = 1'b1;
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    instr = 32'hDEAD_BEEF;
  endtask

  task automatic run(input logic [31:0] ins, input logic tk, input int dmw, input int lat,
                     input logic [2:0] st, input logic psel, input logic rfwe,
                     input logic [1:0] wb, input logic [4:0] rdx, input logic [2:0] f3,
                     input logic sub, input bit has_mem, input logic mwe, input int mhold);
    ret_t r;
    mem_t m;
    r.lat = lat; r.st = st; r.psel = psel; r.rfwe = rfwe; r.wb = wb;
    r.rd = rdx; r.f3 = f3; r.sub = sub; r.cnt = exp_cnt;
    ret_q.push_back(r);
    exp_cnt++;
    if (has_mem) begin
      m.we = mwe; m.ctrl = 3'b010; m.hold = mhold;
      mem_q.push_back(m);
    end
    branch_taken = tk;
    dm_wait = dmw;
    fetch(ins);
    wait_state(3'd0);
  endtask

  initial begin
    reset = 1'b1;
    instr = 32'd0;
    imem_ready = 1'b0;
    branch_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",   {29'd0, state}, 32'd0);
    chk("rst_instret", instret_cnt, 32'd0);
    chk("rst_trap",    {31'd0, trap}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    #1;
    chk("first_imem_req", {31'd0, imem_req}, 32'd1);

    //   instr         tk dmw lat st   ps rf wb    rd f3   sub mem we hold
    run(32'h002081B3, 0, 0, 4, 3'd4, 0, 1, 2'b01, 3, 3'd0, 0, 0, 0, 0);  // add x3,x1,x2
    chk("instret_add", instret_cnt, 32'd1);
    run(32'h0080A283, 0, 3, 8, 3'd4, 0, 1, 2'b00, 5, 3'd0, 0, 1, 0, 4);  // lw, 3 wait
    run(32'h00208463, 1, 0, 3, 3'd2, 1, 0, 2'b01, 8, 3'd0, 0, 0, 0, 0);  // beq taken
    run(32'h00208463, 0, 0, 3, 3'd2, 0, 0, 2'b01, 8, 3'd0, 0, 0, 0, 0);  // beq not taken
    run(32'h40225213, 0, 0, 4, 3'd4, 0, 1, 2'b01, 4, 3'd5, 1, 0, 0, 0);  // srai x4,x4,2
    run(32'h40000313, 0, 0, 4, 3'd4, 0, 1, 2'b01, 6, 3'd0, 0, 0, 0, 0);  // addi, IR[30]=1
    run(32'h0020A223, 0, 0, 4, 3'd3, 0, 0, 2'b01, 4, 3'd0, 0, 1, 1, 1);  // sw
    run(32'h010000EF, 0, 0, 4, 3'd4, 1, 1, 2'b10, 1, 3'd0, 0, 0, 0, 0);  // jal x1
    run(32'h123453B7, 0, 0, 4, 3'd4, 0, 1, 2'b11, 7, 3'd0, 0, 0, 0, 0);  // lui x7
    run(32'h40208433, 0, 0, 4, 3'd4, 0, 1, 2'b01, 8, 3'd0, 1, 0, 0, 0);  // sub x8
    run(32'h00208033, 0, 0, 4, 3'd4, 0, 0, 2'b01, 0, 3'd0, 0, 0, 0, 0);  // add x0
    run(32'h0080A283, 0, 0, 5, 3'd4, 0, 1, 2'b00, 5, 3'd0, 0, 1, 0, 1);  // lw, zero wait
    chk("instret_mid", instret_cnt, 32'd12);

`ifdef MC_CU_TRAP_EN
    fetch(32'h0000007F);
    repeat (4) @(posedge clk);
    #1;
    chk("trap_state",   {29'd0, state}, 32'd5);
    chk("trap_flag",    {31'd0, trap}, 32'd1);
    chk("trap_pc_we",   {31'd0, pc_we}, 32'd0);
    chk("trap_instret", instret_cnt, 32'd12);
    reset = 1'b1;
    #1;
    chk("trap_cleared", {31'd0, trap}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cnt = 0;
`else
    run(32'h0000007F, 0, 0, 3, 3'd2, 0, 0, 2'b01, 0, 3'd0, 0, 0, 0, 0);  // unknown -> NOP
    chk("instret_nop", instret_cnt, 32'd13);
`endif

    // Store interrupted by reset while waiting in MEM
    dm_wait = 20;
    fetch(32'h0020A223);
    wait_state(3'd3);
    @(posedge clk);
    #1;
    chk("mem_held_req", {31'd0, dmem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmem_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rstmem_state",    {29'd0, state}, 32'd0);
    chk("rstmem_instret",  instret_cnt, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cnt = 0;
    dm_wait = 0;

    run(32'h002081B3, 0, 0, 4, 3'd4, 0, 1, 2'b01, 3, 3'd0, 0, 0, 0, 0);
    chk("instret_after_rst", instret_cnt, 32'd1);

    repeat (3) @(posedge clk);
    chk("ret_q_empty", ret_q.size(), 32'd0);
    chk("mem_q_empty", mem_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
